control_divisor: RTL and testbench

- Run/stop and rate controller for the frequency-divider datapath.
- Produces a divided square wave `clk_out` and a rising-edge `tick` strobe from `clk`.
- Accepts new half-period values from a requester over a valid/ready handshake.
- Applies each new rate only at a full-period boundary, so `clk_out` never has a truncated or glitched period.
- Sits between the VGA/timing logic (requester) and the free-running clock domain.

---
 rtl/control_divisor.sv | 140 ++++++++++++++
 tb/tb_control_divisor.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_divisor.sv
// Run/stop and rate controller: divides clk into clk_out/tick and applies new rates only at full-period boundaries.
// Optional macro DIV_PERIOD_CNT_EN adds a 16-bit period_cnt output counting completed periods.
module control_divisor #(
  parameter int F_IN     = 75000000,
  parameter int CNT_W    = 26,
  parameter int DEF_HALF = F_IN / 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_half,
  output logic             cfg_ready,
  output logic             clk_out,
  output logic             tick,
  output logic             running
`ifdef DIV_PERIOD_CNT_EN
  ,
  output logic [15:0]      period_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] DEF_EFF = (DEF_HALF == 0) ? CNT_W'(1) : CNT_W'(DEF_HALF);

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] half;
  logic [CNT_W-1:0] pending;
  logic             pend;

  logic xfer;
  logic toggle;
  logic rise;
  logic fall;
  logic quick_stop;

  // A zero half-period would never toggle, so it is promoted to 1 (clk/2)
  function automatic logic [CNT_W-1:0] eff_half(input logic [CNT_W-1:0] v);
    return (v == '0) ? CNT_W'(1) : v;
  endfunction

  assign cfg_ready  = (state == ST_STOP) || ((state == ST_RUN) && !pend);
  assign running    = (state != ST_STOP);
  assign xfer       = cfg_valid && cfg_ready;
  assign toggle     = (count == (half - CNT_W'(1)));
  assign rise       = toggle && !clk_out;
  assign fall       = toggle && clk_out;
  // Stopping at the very start of a period needs no drain: the output is already low
  assign quick_stop = (state == ST_RUN) && !en && !clk_out && (count == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_STOP;
      count   <= '0;
      half    <= DEF_EFF;
      pending <= '0;
      pend    <= 1'b0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
`ifdef DIV_PERIOD_CNT_EN
      period_cnt <= 16'd0;
`endif
    end else begin
      case (state)
        ST_STOP: begin
          count   <= '0;
          clk_out <= 1'b0;
          tick    <= 1'b0;
          pend    <= 1'b0;
          if (xfer) begin
            half <= eff_half(cfg_half);
          end else if (pend) begin
            half <= pending;
          end
          if (en) begin
            state <= ST_RUN;
`ifdef DIV_PERIOD_CNT_EN
            period_cnt <= 16'd0;
`endif
          end
        end
        ST_RUN, ST_DRAIN: begin
          if (quick_stop) begin
            state   <= ST_STOP;
            count   <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
            pend    <= 1'b0;
            if (xfer) begin
              half <= eff_half(cfg_half);
            end else if (pend) begin
              half <= pending;
            end
          end else begin
            tick <= rise;
            if (toggle) begin
              count   <= '0;
              clk_out <= ~clk_out;
            end else begin
              count <= count + CNT_W'(1);
            end
            // Falling edge closes a full period: safe point for rate change and stop
            if (fall) begin
`ifdef DIV_PERIOD_CNT_EN
              period_cnt <= period_cnt + 16'd1;
`endif
              if (pend) begin
                half <= pending;
                pend <= 1'b0;
              end
              if ((state == ST_DRAIN) || !en) begin
                state <= ST_STOP;
              end
            end else if ((state == ST_RUN) && !en) begin
              state <= ST_DRAIN;
            end
            if (xfer) begin
              pending <= eff_half(cfg_half);
              pend    <= 1'b1;
            end
          end
        end
        default: begin
          state   <= ST_STOP;
          count   <= '0;
          clk_out <= 1'b0;
          tick    <= 1'b0;
          pend    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_control_divisor.sv
// Directed bench for control_divisor: a period-position model checked every cycle plus literal timing checks.
module tb_control_divisor;

  localparam int CNT_W    = 26;
  localparam int DEF_HALF = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_half;
  logic             cfg_ready;
  logic             clk_out;
  logic             tick;
  logic             running;
`ifdef DIV_PERIOD_CNT_EN
  logic [15:0]      period_cnt;
`endif

  control_divisor #(.F_IN(8), .CNT_W(CNT_W), .DEF_HALF(DEF_HALF)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_half  (cfg_half),
    .cfg_ready (cfg_ready),
    .clk_out   (clk_out),
    .tick      (tick),
    .running   (running)
`ifdef DIV_PERIOD_CNT_EN
    ,
    .period_cnt(period_cnt)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  // Model: mode 0=stopped 1=running 2=draining; pos = position within the 2*h-cycle period
  int m_mode, m_pos, m_h, m_pend, m_pv, m_tick, m_pc;

  int entry_cyc = 0, last_tick_cyc = 0, last_fall_cyc = 0;
  int rise_delay = 0, tick_iv = 0, fall_iv = 0;
  bit saw_tick, saw_fall;
  logic prev_clk_out = 1'b0, prev_running = 1'b0;

  function automatic int effh(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  task automatic check(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_pos = 0; m_h = DEF_HALF; m_pend = 0; m_pv = 0; m_tick = 0; m_pc = 0;
  endtask

  function automatic int m_ready();
    return ((m_mode == 0) || (m_mode == 1 && m_pend == 0)) ? 1 : 0;
  endfunction

  // Advance the model by one clk edge using the inputs currently applied
  task automatic model_next();
    int xfer, npos, oldpend;
    if (rst) begin
      model_reset();
      return;
    end
    xfer = (cfg_valid && m_ready() == 1) ? 1 : 0;
    if (m_mode == 0) begin
      if (xfer == 1) m_h = effh(int'(cfg_half));
      else if (m_pend == 1) m_h = m_pv;
      m_pend = 0; m_pos = 0; m_tick = 0;
      if (en) begin m_mode = 1; m_pc = 0; end
    end else if (m_mode == 1 && !en && m_pos == 0) begin
      if (xfer == 1) m_h = effh(int'(cfg_half));
      else if (m_pend == 1) m_h = m_pv;
      m_pend = 0; m_mode = 0; m_tick = 0;
    end else begin
      oldpend = m_pend;
      npos = m_pos + 1;
      m_tick = (npos == m_h) ? 1 : 0;
      if (npos == 2 * m_h) begin
        npos = 0;
        m_pc = (m_pc + 1) % 65536;
        if (oldpend == 1) begin m_h = m_pv; m_pend = 0; end
        if (m_mode == 2 || !en) m_mode = 0;
      end else if (m_mode == 1 && !en) begin
        m_mode = 2;
      end
      m_pos = npos;
      if (xfer == 1) begin m_pv = effh(int'(cfg_half)); m_pend = 1; end
    end
  endtask

  task automatic compare_outputs();
    int e_clk, e_run;
    e_clk = (m_mode != 0 && m_pos >= m_h) ? 1 : 0;
    e_run = (m_mode != 0) ? 1 : 0;
    vectors++;
    if (int'(clk_out) != e_clk || int'(tick) != m_tick || int'(running) != e_run ||
        int'(cfg_ready) != m_ready()) begin
      errors++;
      $display("FAIL cycle %0d outputs: got clk_out=%0b tick=%0b running=%0b cfg_ready=%0b expected %0d %0d %0d %0d",
               cyc, clk_out, tick, running, cfg_ready, e_clk, m_tick, e_run, m_ready());
    end
`ifdef DIV_PERIOD_CNT_EN
    check("period_cnt_model", int'(period_cnt), m_pc);
`endif
  endtask

  task automatic step();
    model_next();
    @(posedge clk);
    #1;
    cyc++;
    compare_outputs();
    saw_tick = 1'b0;
    saw_fall = 1'b0;
    if (running && !prev_running) entry_cyc = cyc;
    if (tick) begin
      tick_iv = cyc - last_tick_cyc;
      rise_delay = cyc - entry_cyc;
      last_tick_cyc = cyc;
      saw_tick = 1'b1;
    end
    if (prev_clk_out && !clk_out) begin
      fall_iv = cyc - last_fall_cyc;
      last_fall_cyc = cyc;
      saw_fall = 1'b1;
    end
    prev_clk_out = clk_out;
    prev_running = running;
  endtask

  task automatic wait_tick(input string name);
    int n = 0;
    do begin step(); n++; end while (!saw_tick && n < 200);
    if (!saw_tick) check({name, "_timeout"}, 0, 1);
  endtask

  task automatic wait_fall(input string name);
    int n = 0;
    do begin step(); n++; end while (!saw_fall && n < 200);
    if (!saw_fall) check({name, "_timeout"}, 0, 1);
  endtask

  task automatic wait_stopped(input string name);
    int n = 0;
    while (running && n < 200) begin step(); n++; end
    check({name, "_stopped"}, int'(running), 0);
  endtask

  // Steps until the model's current period position equals target (running)
  task automatic wait_pos(input int target, input string name);
    int n = 0;
    while (!(m_mode == 1 && m_pos == target) && n < 200) begin step(); n++; end
    check({name, "_pos_reached"}, (m_mode == 1 && m_pos == target) ? 1 : 0, 1);
  endtask

  task automatic transfer(input int value);
    cfg_valid = 1'b1;
    cfg_half  = CNT_W'(value);
    step();
    cfg_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_half = '0;
    model_reset();
    #1;
    check("reset_clk_out", int'(clk_out), 0);
    check("reset_tick", int'(tick), 0);
    check("reset_running", int'(running), 0);
    check("reset_cfg_ready", int'(cfg_ready), 1);
    step();
    step();
    rst = 1'b0;
    step();

    // Default rate: first rise 4 edges after entry, 8-cycle period
    en = 1'b1;
    step();
    wait_tick("first_rise");
    check("first_rise_delay", rise_delay, 4);
    wait_tick("period8");
    check("tick_interval_8", tick_iv, 8);

    // Rate change to 2 requested in the high phase
    wait_pos(DEF_HALF + 1, "mid_high");
    transfer(2);
    check("ready_low_pending", int'(cfg_ready), 0);
    wait_fall("req_period");
    check("req_period_8", fall_iv, 8);
    wait_fall("new_period");
    check("new_period_4", fall_iv, 4);

    // Back to 4, then a transfer on the falling-toggle edge itself
    transfer(4);
    wait_fall("to4_a");
    wait_fall("to4_b");
    wait_pos(7, "pre_fall");
    transfer(3);
    check("same_edge_fall_seen", int'(saw_fall), 1);
    wait_fall("same_edge_a");
    check("same_edge_period_8", fall_iv, 8);
    wait_fall("same_edge_b");
    check("after_change_6", fall_iv, 6);

    // Stop request in the high phase with a pending value of 5
    wait_pos(3, "high3");
    transfer(5);
    en = 1'b0;
    step();
    check("drain_running", int'(running), 1);
    wait_stopped("drain");
    check("stop_clk_out", int'(clk_out), 0);
    en = 1'b1;
    step();
    wait_tick("restart_rise");
    check("restart_rise_5", rise_delay, 5);
    wait_tick("restart_period");
    check("restart_tick_10", tick_iv, 10);

    // Zero half-period stored as 1
    en = 1'b0;
    wait_stopped("stop_for_zero");
    transfer(0);
    en = 1'b1;
    step();
    wait_tick("zero_rise");
    check("zero_rise_1", rise_delay, 1);
    wait_tick("zero_period");
    check("zero_tick_2", tick_iv, 2);
`ifdef DIV_PERIOD_CNT_EN
    en = 1'b0;
    wait_stopped("pc_stop");
    en = 1'b1;
    step();
    wait_fall("pc1");
    wait_fall("pc2");
    wait_fall("pc3");
    check("period_cnt_3", int'(period_cnt), 3);
    en = 1'b0;
    wait_stopped("pc_stop2");
    en = 1'b1;
    step();
    check("period_cnt_cleared", int'(period_cnt), 0);
`endif

    // Async reset in RUN with a pending value
    transfer(4);
    transfer(7);
    wait_pos(1, "pre_reset");
    transfer(9);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_clk_out", int'(clk_out), 0);
    check("async_rst_tick", int'(tick), 0);
    check("async_rst_running", int'(running), 0);
    check("async_rst_ready", int'(cfg_ready), 1);
    model_reset();
    en = 1'b0;
    step();
    rst = 1'b0;
    en = 1'b1;
    step();
    wait_tick("post_reset_rise");
    check("post_reset_rise_4", rise_delay, 4);
    wait_tick("post_reset_period");
    check("post_reset_tick_8", tick_iv, 8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
